sha256_round_core: RTL and testbench
====================================

// Module: sha256_round_core
// PURPOSE
//  SHA-256 compression engine: accepts one 512-bit message block plus 256-bit chaining value,
//  runs 64 rounds with an on-the-fly message schedule, presents final working vars a..h.
//  Sits directly upstream of the per-word H-register/adder stages (H1..H8).
//  Each H stage consumes its word (a_out feeds H1, and so on) on the done pulse.
// PARAMETERS
//  (none; SHA-256 widths fixed: word 32, block 512, state 256)
// PORTS
//  clk        in   1    system clock, all logic on posedge
//  rst_n      in   1    synchronous reset, active low
//  in_valid   in   1    block + chain presented
//  in_ready   out  1    core can accept a block
//  msg_in     in   512  message block; msg_in[511:480] = W0 ... msg_in[31:0] = W15
//  chain_in   in   256  H0..H7; chain_in[255:224] = H0 (initial a)
//  done       out  1    one-cycle pulse: a_out..h_out valid and final
//  busy       out  1    high from accept until done
//  a_out..h_out out 32 each  final working variables (a_out -> H1 stage)
// BEHAVIOUR
//  - Interface: one clock, clk; reset is synchronous and active-low, rst_n.
//  - Reset (rst_n=0 at posedge): state IDLE, in_ready=1, busy=0, done=0, a_out..h_out=0,
//    round counter=0, schedule window cleared. Reset mid-ROUND aborts the block, no done.
//  - Accept: in_valid & in_ready at posedge. Latch a..h <= chain_in, window <= W0..W15, t <= 0.
//  - FSM: IDLE -(accept)-> ROUND -(t==63 computed)-> DONE -(1 cycle)-> IDLE.
//    in_ready=1 in IDLE and DONE; accept in DONE goes straight to ROUND (back-to-back).
//  - ROUND: one round per clock. T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t];
//    T2 = S0(a) + Maj(a,b,c); all adds mod 2^32 (carry out discarded).
//    S0 = ROTR2^ROTR13^ROTR22; S1 = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g);
//    Maj = (a&b)^(a&c)^(b&c).
//  - Schedule: 16-word shift window; W[t] = window[0] for t<16; for t>=16 the new word is
//    s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]; s0 = ROTR7^ROTR18^SHR3;
//    s1 = ROTR17^ROTR19^SHR10. Window shifts one word per round.
//  - Latency: accept at cycle 0; rounds on cycles 1..64; done=1 during cycle 65.
//  - a_out..h_out update only when the final round retires; held stable until next done.
//  - in_valid while busy (not DONE) is ignored; msg_in/chain_in need only be stable at accept.
//  - Core does NOT add chain_in to outputs; the H stages perform the feed-forward.
// CONFIGURATION
//  SHA_DOUBLE_ROUND_EN defined: two rounds per clock (two chained round datapaths, two
//    schedule words per cycle, t steps by 2); rounds on cycles 1..32, done in cycle 33.
//  Undefined: single round per clock, latency per above. Ports/results identical either way.
// STRUCTURE
//  Package sha256_pkg: K[0:63] constant table, IV constants H0..H7, word_t (32-bit) typedef,
//    functions big_sigma0/1, small_sigma0/1, ch, maj, FSM state enum.
//  Sub-module sha256_msg_sched: 16-word window, emits W[t] (and W[t+1] in double mode),
//    load/advance controls from the core FSM.
// TESTING
//  1 FIPS "abc": msg W0=0x61626380, W1..W14=0, W15=0x00000018, chain=IV ->
//    done at cycle 65, a_out=0x506E3058, h_out=0x961F4894 (IV+out = ba7816bf.., f20015ad).
//  2 Reset: assert rst_n=0 at round 30 -> next cycle in_ready=1, busy=0, outputs 0, no done.
//  3 Back-to-back: second "abc" block accepted in the DONE cycle -> second done at cycle 130,
//    same a_out; first block's outputs stable in between.
//  4 Busy ignore: pulse in_valid with all-ones msg at cycle 10 -> no effect, results as test 1.
//  5 Zero block: msg=0, chain=0 -> compare a_out..h_out against reference model, done cycle 65.
//  6 SHA_DOUBLE_ROUND_EN build: rerun test 1 -> identical outputs, done at cycle 33.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word and working-state types, FSM states,
// round constants, IV, the sigma/choice/majority helpers and one full round.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // Working variables a..h; a occupies the most significant word so a
    // 256-bit chaining value maps directly onto this struct.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // One compression round; all sums wrap modulo 2^32.
    function automatic work_t sha_round(input work_t s, input word_t k, input word_t w);
        word_t t1;
        word_t t2;
        work_t r;
        t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
        t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
        r.a = t1 + t2;
        r.b = s.a;
        r.c = s.b;
        r.d = s.c;
        r.e = s.d + t1;
        r.f = s.e;
        r.g = s.f;
        r.h = s.g;
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Message schedule: a 16-word shift window holding W[t..t+15]. Loaded with
// the block on accept, then advanced once per clock while rounds run.
// SHA_DOUBLE_ROUND_EN: emits W[t+1] as well and shifts two words per clock.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic [511:0] msg_in,
    output word_t        w_cur
`ifdef SHA_DOUBLE_ROUND_EN
    ,
    output word_t        w_nxt
`endif
);

    word_t window [0:15];
    word_t new0;
`ifdef SHA_DOUBLE_ROUND_EN
    word_t new1;
`endif

    // Expansion of the next schedule word(s) from the current window contents.
    always_comb begin
        new0 = small_sigma1(window[14]) + window[9] + small_sigma0(window[1]) + window[0];
`ifdef SHA_DOUBLE_ROUND_EN
        new1 = small_sigma1(window[15]) + window[10] + small_sigma0(window[2]) + window[1];
`endif
    end

    assign w_cur = window[0];
`ifdef SHA_DOUBLE_ROUND_EN
    assign w_nxt = window[1];
`endif

    // Window register: clear, load a fresh block, or shift in expanded words.
    // NOTE: non-blocking assignments let every window slot read its neighbour's old value in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the window is a small register file, not RAM, so clearing it on reset is cheap and keeps state deterministic.
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) window[i] <= msg_in[511-32*i -: 32];
        end else if (advance) begin
`ifdef SHA_DOUBLE_ROUND_EN
            for (int i = 0; i < 14; i++) window[i] <= window[i+2];
            window[14] <= new0;
            window[15] <= new1;
`else
            for (int i = 0; i < 15; i++) window[i] <= window[i+1];
            window[15] <= new0;
`endif
        end
    end

endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression engine: latches a 512-bit block and 256-bit chaining
// value, runs 64 rounds, then pulses done with the final working variables.
// No feed-forward addition here; downstream H stages add the chaining value.
// SHA_DOUBLE_ROUND_EN: two chained rounds per clock (32 round cycles).
module sha256_round_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] msg_in,
    input  logic [255:0] chain_in,
    output logic         done,
    output logic         busy,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [31:0]  e_out,
    output logic [31:0]  f_out,
    output logic [31:0]  g_out,
    output logic [31:0]  h_out
);

`ifdef SHA_DOUBLE_ROUND_EN
    localparam logic [5:0] T_STEP = 6'd2;
    localparam logic [5:0] T_LAST = 6'd62;
`else
    localparam logic [5:0] T_STEP = 6'd1;
    localparam logic [5:0] T_LAST = 6'd63;
`endif

    state_t     state;
    logic [5:0] t;
    work_t      work;
    work_t      round_res;
    word_t      w_cur;
    logic       load;
    logic       advance;
`ifdef SHA_DOUBLE_ROUND_EN
    word_t      w_nxt;
    work_t      round_mid;
`endif

    // in_ready is only high in IDLE and DONE, so this is the accept condition.
    assign load    = in_valid && in_ready;
    assign advance = (state == ST_ROUND);

    sha256_msg_sched u_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .msg_in  (msg_in),
        .w_cur   (w_cur)
`ifdef SHA_DOUBLE_ROUND_EN
        ,
        .w_nxt   (w_nxt)
`endif
    );

    // Round datapath for the current cycle (one or two chained rounds).
`ifdef SHA_DOUBLE_ROUND_EN
    always_comb begin
        round_mid = sha_round(work, K[t], w_cur);
        round_res = sha_round(round_mid, K[{t[5:1], 1'b1}], w_nxt);
    end
`else
    always_comb begin
        round_res = sha_round(work, K[t], w_cur);
    end
`endif

    // Control FSM with registered handshake flags, working state and results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            t        <= '0;
            work     <= '0;
            {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_valid) begin
                        state    <= ST_ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        work     <= chain_in;
                        t        <= '0;
                    end else begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    work <= round_res;
                    t    <= t + T_STEP;
                    if (t == T_LAST) begin
                        state    <= ST_DONE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <= round_res;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_core.sv
// Self-checking bench for sha256_round_core: table of blocks checked against
// FIPS constants and an independent compression model, plus hand-written
// sequences for reset abort, back-to-back accept and in_valid while busy.
// Define SHA_DOUBLE_ROUND_EN for the bench and RTL together.
module tb_sha256_round_core;

`ifdef SHA_DOUBLE_ROUND_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 64;
`endif
    localparam int TIMEOUT = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] msg_in;
    logic [255:0] chain_in;
    logic         done;
    logic         busy;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
    logic [255:0] outs;

    int errors = 0;
    int checks = 0;

    assign outs = {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};

    always #5 clk = ~clk;

    sha256_round_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .msg_in   (msg_in),
        .chain_in (chain_in),
        .done     (done),
        .busy     (busy),
        .a_out    (a_out),
        .b_out    (b_out),
        .c_out    (c_out),
        .d_out    (d_out),
        .e_out    (e_out),
        .f_out    (f_out),
        .g_out    (g_out),
        .h_out    (h_out)
    );

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV_C =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    // SHA-256("abc") digest minus IV, word by word (mod 2^32).
    localparam logic [255:0] ABC_EXP =
        256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression with a fully expanded 64-word schedule.
    function automatic logic [255:0] ref_compress(input logic [511:0] m, input logic [255:0] c);
        logic [31:0] w [64];
        logic [31:0] a, b, cc, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        {a, b, cc, d, e, f, g, h} = c;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & cc) ^ (b & cc));
            h = g; g = f; f = e; e = d + t1;
            d = cc; cc = b; b = a; a = t1 + t2;
        end
        return {a, b, cc, d, e, f, g, h};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: offer the block, let one posedge accept it, then
    // scramble the inputs so only the accept-edge values can matter.
    task automatic start_block(input logic [511:0] m, input logic [255:0] c);
        in_valid = 1'b1;
        msg_in   = m;
        chain_in = c;
        check("in_ready_at_offer", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        msg_in   = ~m;
        chain_in = ~c;
        check("busy_ready_after_accept", {busy, in_ready}, 2'b10);
    endtask

    // Counts posedges from the accept edge until done is seen; optionally pulses
    // in_valid with all-ones data and tracks that outputs hold a given value.
    task automatic wait_done(input int glitch_at, input logic [255:0] hold_val, input bit check_hold,
                             output int lat, output bit held);
        lat  = 0;
        held = 1'b1;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (lat == glitch_at) begin
                in_valid = 1'b1;
                msg_in   = '1;
                chain_in = '1;
            end else begin
                in_valid = 1'b0;
            end
            if (check_hold && outs !== hold_val) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (lat >= TIMEOUT) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        string        name;
        logic [511:0] msg;
        logic [255:0] chain;
        logic [255:0] exp;
    } vec_t;

    vec_t         vecs [3];
    logic [511:0] abc_msg;
    logic [511:0] pat_msg;
    int           lat;
    bit           held;
    bit           saw_done;

    initial begin
        abc_msg = {32'h61626380, {14{32'h0}}, 32'h00000018};
        for (int i = 0; i < 16; i++) pat_msg[511-32*i -: 32] = 32'h9e3779b9 * (i + 1);

        vecs[0] = '{"abc",  abc_msg, IV_C,   ABC_EXP};
        vecs[1] = '{"zero", '0,      '0,     ref_compress('0, '0)};
        vecs[2] = '{"pat",  pat_msg, IV_C,   ref_compress(pat_msg, IV_C)};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        msg_in   = '0;
        chain_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_flags", {in_ready, busy, done}, 3'b100);
        check("reset_outs", outs, '0);

        // Table of blocks.
        foreach (vecs[v]) begin
            start_block(vecs[v].msg, vecs[v].chain);
            wait_done(-1, '0, 1'b0, lat, held);
            check({vecs[v].name, "_latency"}, lat, LAT);
            check({vecs[v].name, "_outs"}, outs, vecs[v].exp);
            @(negedge clk);
            check({vecs[v].name, "_done_one_cycle"}, {done, in_ready, busy}, 3'b010);
            check({vecs[v].name, "_outs_held_idle"}, outs, vecs[v].exp);
        end

        // Reset during round 30 aborts the block with no done.
        start_block(abc_msg, IV_C);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_flags", {in_ready, busy, done}, 3'b100);
        check("abort_outs", outs, '0);
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        // Back-to-back: second block accepted in the DONE cycle.
        start_block(abc_msg, IV_C);
        wait_done(-1, '0, 1'b0, lat, held);
        check("b2b_first_latency", lat, LAT);
        check("b2b_first_outs", outs, ABC_EXP);
        check("b2b_done_at_offer", done, 1);
        start_block(abc_msg, IV_C);
        wait_done(-1, ABC_EXP, 1'b1, lat, held);
        check("b2b_second_latency", lat, LAT);
        check("b2b_outs_stable", held, 1);
        check("b2b_second_outs", outs, ABC_EXP);
        @(negedge clk);

        // in_valid with all-ones data while busy must be ignored.
        start_block(abc_msg, IV_C);
        wait_done(9, '0, 1'b0, lat, held);
        check("busy_ignore_latency", lat, LAT);
        check("busy_ignore_outs", outs, ABC_EXP);
        @(negedge clk);
        check("busy_ignore_idle", {done, in_ready, busy}, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
